// File: rtl/net_pkg.sv
// net_pkg: shared protocol constants and L4 parser state encoding
package net_pkg;
  localparam logic [7:0] IP_PROTO_UDP  = 8'd17;
  localparam logic [7:0] IP_PROTO_TCP  = 8'd6;
  localparam int         IPV4_MIN_HDR  = 20;
  localparam int         UDP_HDR_LEN   = 8;
  localparam int         TCP_FLAGS_OFF = 13;
  typedef enum logic [2:0] {IDLE, IP_HDR, L4_HDR, WAIT_PROTO, PAYLOAD, DROP} l4_state_t;
endpackage

// File: rtl/l4_parser.sv
// l4_parser: locates the UDP/TCP header behind the IPv4 header, extracts ports/length/flags, re-registers the stream
// Ports: clk, rst_n (async, active-low); tdata_in/idx_in/data_valid_in/last_flag_in input stream;
//   ipv4_parser_ready/protocol_in from the IPv4 parser; *_out stream delayed one cycle;
//   l4_parser_ready, src_port, dst_port, udp_length, tcp_flags, l4_err decision outputs.
// Build option: define L4_TCP_PARSE_EN to accept TCP (protocol 6) and capture tcp_flags.
module l4_parser
  import net_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DATA_WIDTH-1:0]               tdata_in,
  input  logic [$clog2(DATA_WIDTH/8+1)-1:0]   idx_in,
  input  logic                                data_valid_in,
  input  logic                                last_flag_in,
  input  logic                                ipv4_parser_ready,
  input  logic [7:0]                          protocol_in,
  output logic [DATA_WIDTH-1:0]               tdata_out,
  output logic [$clog2(DATA_WIDTH/8+1)-1:0]   idx_out,
  output logic                                data_valid_out,
  output logic                                last_flag_out,
  output logic                                l4_parser_ready,
  output logic [15:0]                         src_port,
  output logic [15:0]                         dst_port,
  output logic [15:0]                         udp_length,
  output logic [7:0]                          tcp_flags,
  output logic                                l4_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(NB + 1);
`ifdef L4_TCP_PARSE_EN
  localparam logic [8:0] HDR_END = 9'(TCP_FLAGS_OFF);
`else
  localparam logic [8:0] HDR_END = 9'(UDP_HDR_LEN - 1);
`endif
  l4_state_t             r_state, w_state;
  logic [7:0]            r_cnt, w_cnt;
  logic [3:0]            r_ihl, w_ihl;
  logic [15:0]           r_src, w_src, r_dst, w_dst, r_len, w_len;
  logic [7:0]            r_flags, w_flags;
  logic                  r_ready, w_ready, r_err, w_err;
  logic [8:0]            w_base, w_off, w_l4_off, w_rel, w_sum;
  logic [7:0]            w_byte;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [IW-1:0]         r_idx;
  logic                  r_valid, r_last;

  // Lanes are walked in order so the header boundary and field captures can
  // all fall inside one beat; offsets are 9 bits so cnt+lane never wraps.
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_ihl = r_ihl;
    w_src = r_src;
    w_dst = r_dst;
    w_len = r_len;
    w_flags = r_flags;
    w_ready = r_ready;
    w_err = r_err;
    w_base = r_state == IDLE ? 9'd0 : {1'b0, r_cnt};
    w_off = '0;
    w_l4_off = '0;
    w_rel = '0;
    w_byte = '0;
    w_sum = w_base + 9'(idx_in);
    if (data_valid_in && idx_in != '0) begin
      if (r_state == IDLE) begin
        w_state = IP_HDR;
        w_ready = 1'b0;
        w_err = 1'b0;
        w_src = '0;
        w_dst = '0;
        w_len = '0;
        w_flags = '0;
      end
      for (int l = 0; l < NB; l++) begin
        if (l < int'(idx_in)) begin
          w_off = w_base + 9'(l);
          w_byte = tdata_in[l*8 +: 8];
          if (w_state == IP_HDR && w_off == 9'd0) begin
            w_ihl = w_byte[3:0];
            if (w_byte[7:4] != 4'd4) begin
              w_err = 1'b1;
              w_state = DROP;
            end
          end
          w_l4_off = w_ihl >= 4'd5 ? {3'b0, w_ihl, 2'b0} : 9'(IPV4_MIN_HDR);
          if (w_state == IP_HDR && w_off >= w_l4_off) w_state = L4_HDR;
          if (w_state == L4_HDR) begin
            w_rel = w_off - w_l4_off;
            w_src = w_rel == 9'd0 ? {w_byte, w_src[7:0]} : w_rel == 9'd1 ? {w_src[15:8], w_byte} : w_src;
            w_dst = w_rel == 9'd2 ? {w_byte, w_dst[7:0]} : w_rel == 9'd3 ? {w_dst[15:8], w_byte} : w_dst;
            w_len = w_rel == 9'd4 ? {w_byte, w_len[7:0]} : w_rel == 9'd5 ? {w_len[15:8], w_byte} : w_len;
`ifdef L4_TCP_PARSE_EN
            if (w_rel == 9'(TCP_FLAGS_OFF)) w_flags = w_byte;
`endif
            if (w_rel == HDR_END) w_state = WAIT_PROTO;
          end
        end
      end
      w_cnt = w_sum > 9'd255 ? 8'hFF : w_sum[7:0];
    end
    if (w_state == WAIT_PROTO && ipv4_parser_ready) begin
      if (protocol_in == IP_PROTO_UDP) begin
        w_flags = '0;
        w_ready = 1'b1;
        w_state = PAYLOAD;
      end
`ifdef L4_TCP_PARSE_EN
      else if (protocol_in == IP_PROTO_TCP) begin
        w_len = '0;
        w_ready = 1'b1;
        w_state = PAYLOAD;
      end
`endif
      else begin
        w_err = 1'b1;
        w_state = DROP;
      end
    end
    // An idx_in==0 beat carries no bytes but its last flag still ends the frame.
    if (data_valid_in && last_flag_in && w_state != IDLE) begin
      if (w_state inside {IP_HDR, L4_HDR, WAIT_PROTO}) w_err = 1'b1;
      w_state = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_ihl <= '0;
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
      r_flags <= '0;
      r_ready <= 1'b0;
      r_err <= 1'b0;
      r_tdata <= '0;
      r_idx <= '0;
      r_valid <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_ihl <= w_ihl;
      r_src <= w_src;
      r_dst <= w_dst;
      r_len <= w_len;
      r_flags <= w_flags;
      r_ready <= w_ready;
      r_err <= w_err;
      r_tdata <= tdata_in;
      r_idx <= idx_in;
      r_valid <= data_valid_in;
      r_last <= last_flag_in;
    end
  end

  assign tdata_out = r_tdata;
  assign idx_out = r_idx;
  assign data_valid_out = r_valid;
  assign last_flag_out = r_last;
  assign l4_parser_ready = r_ready;
  assign src_port = r_src;
  assign dst_port = r_dst;
  assign udp_length = r_len;
  assign tcp_flags = r_flags;
  assign l4_err = r_err;
endmodule

// File: tb/tb_l4_parser.sv
// tb_l4_parser: scoreboard bench for l4_parser (64-bit stream)
module tb_l4_parser;
  typedef struct {
    logic        rdy;
    logic        err;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [7:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] tdata_in;
  logic [3:0]  idx_in;
  logic        data_valid_in, last_flag_in, ipv4_parser_ready;
  logic [7:0]  protocol_in;
  logic [63:0] tdata_out;
  logic [3:0]  idx_out;
  logic        data_valid_out, last_flag_out, l4_parser_ready, l4_err;
  logic [15:0] src_port, dst_port, udp_length;
  logic [7:0]  tcp_flags;

  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  fr[$];
  logic [63:0] p_tdata;
  logic [3:0]  p_idx;
  logic        p_valid, p_last;

  always #5 clk = ~clk;

  l4_parser #(.DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .tdata_in(tdata_in), .idx_in(idx_in),
    .data_valid_in(data_valid_in), .last_flag_in(last_flag_in),
    .ipv4_parser_ready(ipv4_parser_ready), .protocol_in(protocol_in),
    .tdata_out(tdata_out), .idx_out(idx_out), .data_valid_out(data_valid_out),
    .last_flag_out(last_flag_out), .l4_parser_ready(l4_parser_ready),
    .src_port(src_port), .dst_port(dst_port), .udp_length(udp_length),
    .tcp_flags(tcp_flags), .l4_err(l4_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Prior-cycle copy of the stream inputs, cleared by reset like any register.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_tdata <= '0;
      p_idx <= '0;
      p_valid <= 1'b0;
      p_last <= 1'b0;
    end else begin
      p_tdata <= tdata_in;
      p_idx <= idx_in;
      p_valid <= data_valid_in;
      p_last <= last_flag_in;
    end
  end

  always @(negedge clk) begin
    check("pt_data", tdata_out, p_tdata);
    check("pt_ctl", 64'({idx_out, data_valid_out, last_flag_out}), 64'({p_idx, p_valid, p_last}));
  end

  always @(negedge clk) begin
    if (rst_n && data_valid_out && last_flag_out) begin
      if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        mon_e = sb.pop_front();
        check("ready", 64'(l4_parser_ready), 64'(mon_e.rdy));
        check("err", 64'(l4_err), 64'(mon_e.err));
        check("src_port", 64'(src_port), 64'(mon_e.src));
        check("dst_port", 64'(dst_port), 64'(mon_e.dst));
        check("udp_length", 64'(udp_length), 64'(mon_e.len));
        check("tcp_flags", 64'(tcp_flags), 64'(mon_e.flags));
      end
    end
  end

  task automatic push_exp(input logic rdy, input logic err, input logic [15:0] src, input logic [15:0] dst,
                          input logic [15:0] len, input logic [7:0] flags);
    exp_t e;
    e.rdy = rdy;
    e.err = err;
    e.src = src;
    e.dst = dst;
    e.len = len;
    e.flags = flags;
    sb.push_back(e);
  endtask

  task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input bit tcp, input logic [15:0] src,
                       input logic [15:0] dst, input logic [15:0] len, input logic [7:0] flags, input int total);
    int hl = ihl >= 4'd5 ? int'(ihl) * 4 : 20;
    fr.delete();
    fr.push_back({ver, ihl});
    for (int i = 1; i < hl; i++) fr.push_back(8'(i) ^ 8'hA5);
    fr.push_back(src[15:8]);
    fr.push_back(src[7:0]);
    fr.push_back(dst[15:8]);
    fr.push_back(dst[7:0]);
    fr.push_back(len[15:8]);
    fr.push_back(len[7:0]);
    fr.push_back(8'hC3);
    fr.push_back(8'h3C);
    if (tcp) for (int i = 8; i < 20; i++) fr.push_back(i == 13 ? flags : 8'(i) ^ 8'h5A);
    while (fr.size() < total) fr.push_back(8'(fr.size()) ^ 8'h77);
    while (fr.size() > total) void'(fr.pop_back());
  endtask

  // Drives fr as 8-byte beats; extra appends an empty last beat; maxb cuts the frame short.
  // ready is checked after every beat: high from beat rdy_beat on (never when rdy_beat<0).
  task automatic send(input int ipr_beat, input int rdy_beat, input bit extra, input int maxb);
    int nb = (fr.size() + 7) / 8;
    int tb = nb + int'(extra);
    int lim = tb < maxb ? tb : maxb;
    for (int b = 0; b < lim; b++) begin
      logic [63:0] d = '0;
      int n = b < nb ? fr.size() - b * 8 : 0;
      if (n > 8) n = 8;
      for (int k = 0; k < n; k++) d[k*8 +: 8] = fr[b*8 + k];
      tdata_in = d;
      idx_in = 4'(n);
      data_valid_in = 1'b1;
      last_flag_in = b == tb - 1;
      ipv4_parser_ready = b >= ipr_beat;
      @(negedge clk);
      check("ready_timing", 64'(l4_parser_ready), 64'(rdy_beat >= 0 && b >= rdy_beat));
    end
  endtask

  task automatic idle(input int n);
    data_valid_in = 1'b0;
    last_flag_in = 1'b0;
    idx_in = '0;
    tdata_in = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 64'(l4_parser_ready), 64'd0);
    check({tag, "_err"}, 64'(l4_err), 64'd0);
    check({tag, "_fields"}, {src_port, dst_port, udp_length, 8'(tcp_flags)}, 64'd0);
    check({tag, "_tdata"}, tdata_out, 64'd0);
    check({tag, "_ctl"}, 64'({idx_out, data_valid_out, last_flag_out}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    tdata_in = '0;
    idx_in = '0;
    data_valid_in = 1'b0;
    last_flag_in = 1'b0;
    ipv4_parser_ready = 1'b0;
    protocol_in = 8'd17;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    // UDP, IHL=5: L4 bytes 20..27, last needed byte in beat 3
    build(4'd4, 4'd5, 1'b0, 16'h1234, 16'h0035, 16'h001C, 8'h00, 40);
    push_exp(1'b1, 1'b0, 16'h1234, 16'h0035, 16'h001C, 8'h00);
    send(0, 3, 1'b0, 99);
    idle(2);
    // UDP, IHL=6: L4 bytes 24..31, still complete in beat 3
    build(4'd4, 4'd6, 1'b0, 16'd5000, 16'd6000, 16'd20, 8'h00, 48);
    push_exp(1'b1, 1'b0, 16'd5000, 16'd6000, 16'd20, 8'h00);
    send(0, 3, 1'b0, 99);
    idle(1);
    // TCP, flags 0x12
    protocol_in = 8'd6;
    build(4'd4, 4'd5, 1'b1, 16'h0400, 16'h0050, 16'h7777, 8'h12, 48);
`ifdef L4_TCP_PARSE_EN
    push_exp(1'b1, 1'b0, 16'h0400, 16'h0050, 16'h0000, 8'h12);
    send(0, 4, 1'b0, 99);
`else
    push_exp(1'b0, 1'b1, 16'h0400, 16'h0050, 16'h7777, 8'h00);
    send(0, -1, 1'b0, 99);
`endif
    idle(1);
    // ICMP rejected, then a back-to-back UDP frame clears the error
    protocol_in = 8'd1;
    build(4'd4, 4'd5, 1'b0, 16'h1111, 16'h2222, 16'h0020, 8'h00, 32);
    push_exp(1'b0, 1'b1, 16'h1111, 16'h2222, 16'h0020, 8'h00);
    send(0, -1, 1'b0, 99);
    check("err_held", 64'(l4_err), 64'd1);
    protocol_in = 8'd17;
    build(4'd4, 4'd5, 1'b0, 16'h3333, 16'h4444, 16'h0018, 8'h00, 36);
    push_exp(1'b1, 1'b0, 16'h3333, 16'h4444, 16'h0018, 8'h00);
    send(0, 3, 1'b0, 99);
    idle(3);
    check("hold_gap", 64'({l4_parser_ready, l4_err, src_port}), 64'({2'b10, 16'h3333}));
    // Truncated: 24 bytes, then an empty last beat
    build(4'd4, 4'd5, 1'b0, 16'hAAAA, 16'hBBBB, 16'hCCCC, 8'h00, 24);
    push_exp(1'b0, 1'b1, 16'hAAAA, 16'hBBBB, 16'h0000, 8'h00);
    send(0, -1, 1'b1, 99);
    // Last beat completes the header with ipv4_parser_ready already high
    build(4'd4, 4'd5, 1'b0, 16'h0102, 16'h0304, 16'h0008, 8'h00, 28);
    push_exp(1'b1, 1'b0, 16'h0102, 16'h0304, 16'h0008, 8'h00);
    send(0, 3, 1'b0, 99);
    // ipv4_parser_ready arrives late: decision follows it
    build(4'd4, 4'd5, 1'b0, 16'hBEEF, 16'hCAFE, 16'h002C, 8'h00, 64);
    push_exp(1'b1, 1'b0, 16'hBEEF, 16'hCAFE, 16'h002C, 8'h00);
    send(5, 5, 1'b0, 99);
    // Bad version
    build(4'd6, 4'd5, 1'b0, 16'h5555, 16'h6666, 16'h0010, 8'h00, 32);
    push_exp(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 8'h00);
    send(0, -1, 1'b0, 99);
    // IHL below 5 is treated as a 20-byte header
    build(4'd4, 4'd3, 1'b0, 16'h0A0B, 16'h0C0D, 16'h0009, 8'h00, 30);
    push_exp(1'b1, 1'b0, 16'h0A0B, 16'h0C0D, 16'h0009, 8'h00);
    send(0, 3, 1'b0, 99);
    idle(1);
    // Reset mid-frame after ports were captured
    build(4'd4, 4'd5, 1'b0, 16'h7E7E, 16'h8D8D, 16'h0040, 8'h00, 64);
    send(0, -1, 1'b0, 3);
    check("pre_reset_src", 64'(src_port), 64'h7E7E);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    data_valid_in = 1'b0;
    last_flag_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    build(4'd4, 4'd5, 1'b0, 16'h9876, 16'h5432, 16'h0024, 8'h00, 40);
    push_exp(1'b1, 1'b0, 16'h9876, 16'h5432, 16'h0024, 8'h00);
    send(0, 3, 1'b0, 99);
    idle(4);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
